// File: rtl/life_logic_if.sv
// Bus between the Life next-generation engine and its synchronizer and buffer memories.
// Signal names are given from the engine's side.
interface life_logic_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 48,
    parameter int unsigned ADDR_W = $clog2(HEIGHT),
    parameter int unsigned GEN_W  = 16
) ();
    logic              start_in;
    logic              done_out;
    logic              rd_en_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [WIDTH-1:0]  rd_data_in;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [WIDTH-1:0]  wr_data_out;
    logic [GEN_W-1:0]  gen_count_out;

    modport master (
        output start_in, rd_data_in,
        input  done_out, rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, wr_data_out,
        input  gen_count_out
    );

    modport slave (
        input  start_in, rd_data_in,
        output done_out, rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, wr_data_out,
        output gen_count_out
    );
endinterface

// File: rtl/life_logic.sv
// Game of Life (B3/S23, toroidal) next-generation engine: streams rows from the current
// buffer, keeps a sliding row window and writes each next-generation row one cycle later.
module life_logic #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 48,
    parameter int unsigned ADDR_W = $clog2(HEIGHT),
    parameter int unsigned GEN_W  = 16
) (
    input logic         clk_in,
    input logic         rst_n_in,
    life_logic_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(HEIGHT + 2);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]  LAST_RD  = CNT_W'(HEIGHT + 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_t;

    state_t            r_state;
    logic              r_done;
    logic              r_rd_en;
    logic              r_rd_vld;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_arr_cnt;
    logic [WIDTH-1:0]  r_above;
    logic [WIDTH-1:0]  r_cur;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic [GEN_W-1:0]  r_gen;
    logic [WIDTH-1:0]  w_below;
    logic [WIDTH-1:0]  w_next;

    // Bit x of west() is column x-1, bit x of east() is column x+1, both wrapping.
    function automatic logic [WIDTH-1:0] west(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] east(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    function automatic logic cell_next(input logic [7:0] nb, input logic alive);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(nb[i]);
        end
        return (n == 4'd3) | (alive & (n == 4'd2));
    endfunction

    // The window's lower row is the word arriving this cycle, so the result can be
    // registered on the same edge that would shift it in.
    assign w_below = bus.rd_data_in;

    always_comb begin
        logic [WIDTH-1:0] w_al, w_ar, w_cl, w_cr, w_bl, w_br;
        w_al   = west(r_above);
        w_ar   = east(r_above);
        w_cl   = west(r_cur);
        w_cr   = east(r_cur);
        w_bl   = west(w_below);
        w_br   = east(w_below);
        w_next = '0;
        for (int x = 0; x < int'(WIDTH); x++) begin
            w_next[x] = cell_next({w_al[x], r_above[x], w_ar[x], w_cl[x], w_cr[x],
                                   w_bl[x], w_below[x], w_br[x]}, r_cur[x]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= StIdle;
            r_done    <= 1'b1;
            r_rd_en   <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_arr_cnt <= '0;
            r_above   <= '0;
            r_cur     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_gen     <= '0;
        end else begin
            r_rd_vld <= r_rd_en;
            r_wr_en  <= 1'b0;
            if (r_rd_vld) begin
                r_above   <= r_cur;
                r_cur     <= w_below;
                r_arr_cnt <= r_arr_cnt + CNT_W'(1);
                if (r_arr_cnt >= CNT_W'(2)) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= ADDR_W'(r_arr_cnt - CNT_W'(2));
                    r_wr_data <= w_next;
                end
            end
            unique case (r_state)
                StIdle: begin
                    if (bus.start_in) begin
                        r_state   <= StRead;
                        r_done    <= 1'b0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= LAST_ROW;
                        r_rd_cnt  <= '0;
                    end
                end
                StRead: begin
                    if (r_rd_cnt == LAST_RD) begin
                        r_rd_en <= 1'b0;
                        r_state <= StDrain;
                    end else begin
                        r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
                        r_rd_addr <= (r_rd_addr == LAST_ROW) ? '0 : r_rd_addr + ADDR_W'(1);
                    end
                end
                StDrain: begin
                    if (r_wr_en && (r_wr_addr == LAST_ROW)) begin
                        r_state <= StFinish;
                        r_done  <= 1'b1;
                        r_gen   <= r_gen + GEN_W'(1);
                    end
                end
                StFinish: begin
                    r_state   <= StIdle;
                    r_arr_cnt <= '0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.done_out      = r_done;
    assign bus.rd_en_out     = r_rd_en;
    assign bus.rd_addr_out   = r_rd_addr;
    assign bus.wr_en_out     = r_wr_en;
    assign bus.wr_addr_out   = r_wr_addr;
    assign bus.wr_data_out   = r_wr_data;
    assign bus.gen_count_out = r_gen;
endmodule

// File: tb/tb_life_logic.sv
// Scoreboard bench for life_logic: a neighbour-counting grid model queues expected row
// writes, a monitor pops and compares them as the engine writes its next buffer.
module tb_life_logic;
    localparam int unsigned W  = 64;
    localparam int unsigned H  = 48;
    localparam int unsigned AW = $clog2(H);
    localparam int unsigned GW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    life_logic_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .GEN_W(GW)) bus ();

    life_logic #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .GEN_W(GW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    logic [W-1:0]    mem_cur [H];
    logic [W-1:0]    mem_nxt [H];
    logic [W-1:0]    mdl     [H];
    logic [W-1:0]    saved   [H];
    logic [W-1:0]    shape   [H];
    logic [AW+W-1:0] exp_q   [$];
    logic [AW+W-1:0] exp_e;
    int n_vec   = 0;
    int n_err   = 0;
    int n_wr    = 0;
    int exp_gen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous read (data one cycle after rd_en) and write ports of the two buffers.
    always @(posedge clk) begin
        if (bus.rd_en_out) bus.rd_data_in <= mem_cur[bus.rd_addr_out];
        if (bus.wr_en_out) mem_nxt[bus.wr_addr_out] <= bus.wr_data_out;
    end

    always @(negedge clk) begin
        if (rst_n && bus.wr_en_out) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bus.wr_addr_out), 64'hFFFF);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.wr_addr_out), 64'(exp_e[AW+W-1:W]));
                check("wr_data", 64'(bus.wr_data_out), 64'(exp_e[W-1:0]));
            end
        end
    end

    // Reference: count the eight toroidal neighbours of every cell directly.
    task automatic model_step();
        logic [W-1:0] nxt [H];
        int n;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dy != 0 || dx != 0)
                            n += int'(mdl[(y + dy + int'(H)) % int'(H)][(x + dx + int'(W)) % int'(W)]);
                    end
                end
                nxt[y][x] = (n == 3) || (mdl[y][x] && n == 2);
            end
        end
        for (int y = 0; y < int'(H); y++) exp_q.push_back({AW'(y), nxt[y]});
        mdl = nxt;
    endtask

    task automatic place_glider(input int ox, input int oy);
        int gx [5] = '{1, 2, 0, 1, 2};
        int gy [5] = '{0, 1, 2, 2, 2};
        for (int y = 0; y < int'(H); y++) shape[y] = '0;
        for (int i = 0; i < 5; i++)
            shape[(oy + gy[i]) % int'(H)][(ox + gx[i]) % int'(W)] = 1'b1;
    endtask

    // Called just after a negedge with the engine idle; on success swaps the buffers.
    task automatic run_gen(input int extra_at, input int rst_at);
        int cyc;
        n_wr = 0;
        cyc  = 0;
        bus.start_in = 1'b1;
        @(posedge clk);
        while (cyc == 0 || bus.done_out !== 1'b1) begin
            if (cyc >= 300) begin
                check("done_timeout", 64'(cyc), 64'(H + 5));
                break;
            end
            @(negedge clk);
            cyc++;
            bus.start_in = (cyc == extra_at);
            if (cyc == 1) begin
                check("done_low", 64'(bus.done_out), 64'd0);
                check("first_read", 64'({bus.rd_en_out, bus.rd_addr_out}),
                      64'({1'b1, AW'(H - 1)}));
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_done", 64'(bus.done_out), 64'd1);
                check("rst_rd_en", 64'(bus.rd_en_out), 64'd0);
                check("rst_wr_en", 64'(bus.wr_en_out), 64'd0);
                check("rst_gen", 64'(bus.gen_count_out), 64'd0);
                exp_q.delete();
                exp_gen = 0;
                return;
            end
        end
        check("done_cycle", 64'(cyc), 64'(H + 5));
        check("write_count", 64'(n_wr), 64'(H));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        exp_gen++;
        check("gen_count", 64'(bus.gen_count_out), 64'(exp_gen));
        check("idle_done", 64'(bus.done_out), 64'd1);
        mem_cur = mem_nxt;
    endtask

    initial begin
        bus.start_in = 1'b0;
        for (int y = 0; y < int'(H); y++) begin
            mem_cur[y] = '0;
            mem_nxt[y] = '0;
            mdl[y]     = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_done_rst", 64'(bus.done_out), 64'd1);
            check("idle_rd_en", 64'(bus.rd_en_out), 64'd0);
            check("idle_wr_en", 64'(bus.wr_en_out), 64'd0);
            check("idle_gen", 64'(bus.gen_count_out), 64'd0);
        end

        // Vertical blinker on column 10 turns horizontal on row 5.
        for (int y = 4; y <= 6; y++) mdl[y][10] = 1'b1;
        mem_cur = mdl;
        model_step();
        run_gen(0, 0);
        check("blinker_row5", 64'(mem_cur[5]), 64'h0000_0000_0000_0E00);
        check("blinker_row4", 64'(mem_cur[4]), 64'd0);

        // Glider straddling both wraps reappears offset by (+1,+1) after four generations.
        place_glider(int'(W) - 1, int'(H) - 1);
        mdl     = shape;
        mem_cur = shape;
        for (int g = 0; g < 4; g++) begin
            model_step();
            run_gen(0, 0);
        end
        place_glider(0, 0);
        for (int y = 0; y < int'(H); y++) check("glider_row", 64'(mem_cur[y]), 64'(shape[y]));

        for (int y = 0; y < int'(H); y++) mdl[y] = '1;
        mem_cur = mdl;
        model_step();
        run_gen(0, 0);
        check("all_ones_row0", 64'(mem_cur[0]), 64'd0);

        // 2x2 block split across all four corners is a still life.
        for (int y = 0; y < int'(H); y++) shape[y] = '0;
        shape[0][0] = 1'b1; shape[0][W-1] = 1'b1;
        shape[H-1][0] = 1'b1; shape[H-1][W-1] = 1'b1;
        mdl     = shape;
        mem_cur = shape;
        model_step();
        run_gen(0, 0);
        for (int y = 0; y < int'(H); y++) check("block_row", 64'(mem_cur[y]), 64'(shape[y]));

        model_step();
        run_gen(3, 0);

        saved = mdl;
        model_step();
        run_gen(0, 6);
        mdl = saved;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_step();
        run_gen(0, 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_gen = 0;
        @(negedge clk);
        for (int y = 0; y < int'(H); y++) mdl[y] = {$urandom, $urandom};
        mem_cur = mdl;
        for (int g = 0; g < 100; g++) begin
            model_step();
            run_gen(0, 0);
        end
        check("gen_after_100", 64'(bus.gen_count_out), 64'd100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
